// File: rtl/parking_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | parking_pkg : sizes, FSM encoding and op codes for the spot allocator |
// | Revision    : 1.0                                                     |
// +----------------------------------------------------------------------+
package parking_pkg;
  localparam int N_SPOTS = 8;
  localparam int CNT_W   = 4;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ALLOC   = 2'd1;
  localparam logic [1:0] S_RELEASE = 2'd2;
  localparam logic [1:0] S_RESP    = 2'd3;

  localparam logic OP_ARRIVE = 1'b0;
  localparam logic OP_DEPART = 1'b1;
endpackage
`default_nettype wire

// File: rtl/parking_spot_allocator_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | parking_spot_allocator_if : gate handshakes and lot status signals    |
// | Revision                  : 1.0                                       |
// +----------------------------------------------------------------------+
interface parking_spot_allocator_if;
  import parking_pkg::*;

  logic               arrive_req;
  logic               arrive_ack;
  logic               arrive_full;
  logic [N_SPOTS-1:0] park_location;
  logic               depart_req;
  logic [N_SPOTS-1:0] depart_location;
  logic               depart_ack;
  logic               depart_err;
  logic [N_SPOTS-1:0] parking_capacity;
  logic [CNT_W-1:0]   free_count;
  logic               busy;

  modport master (
    output arrive_req, depart_req, depart_location,
    input  arrive_ack, arrive_full, park_location, depart_ack, depart_err,
           parking_capacity, free_count, busy
  );

  modport slave (
    input  arrive_req, depart_req, depart_location,
    output arrive_ack, arrive_full, park_location, depart_ack, depart_err,
           parking_capacity, free_count, busy
  );
endinterface
`default_nettype wire

// File: rtl/parking_spot_allocator_picker.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lowest_free_picker : one-hot of the lowest clear bit in the bitmap    |
// | Revision           : 1.0                                              |
// +----------------------------------------------------------------------+
module lowest_free_picker
  import parking_pkg::*;
(
  input  logic [N_SPOTS-1:0] occupancy_i,
  output logic [N_SPOTS-1:0] pick_o,
  output logic               any_free_o
);
  // Adding one carries through the trailing ones and lands on the lowest zero.
  assign pick_o     = ~occupancy_i & (occupancy_i + N_SPOTS'(1));
  assign any_free_o = ~&occupancy_i;
endmodule
`default_nettype wire

// File: rtl/parking_spot_allocator.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | parking_spot_allocator : occupancy bitmap owner, arrival/departure FSM|
// | Revision               : 1.0                                          |
// +----------------------------------------------------------------------+
module parking_spot_allocator
  import parking_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  parking_spot_allocator_if.slave  bus
);
  logic [1:0]         state_q, state_d;
  logic               op_q, op_d;
  logic [N_SPOTS-1:0] loc_q, loc_d;
  logic [N_SPOTS-1:0] cap_q, cap_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [N_SPOTS-1:0] park_q, park_d;
  logic               full_q, full_d;
  logic               err_q, err_d;

  logic [N_SPOTS-1:0] pick;
  logic               any_free;
  logic               loc_legal;

  lowest_free_picker u_picker (
    .occupancy_i (cap_q),
    .pick_o      (pick),
    .any_free_o  (any_free)
  );

  assign loc_legal = (loc_q != '0) &&
                     ((loc_q & (loc_q - N_SPOTS'(1))) == '0) &&
                     ((loc_q & cap_q) != '0);

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    loc_d   = loc_q;
    cap_d   = cap_q;
    cnt_d   = cnt_q;
    park_d  = park_q;
    full_d  = full_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (bus.depart_req) begin
          loc_d   = bus.depart_location;
          op_d    = OP_DEPART;
          state_d = S_RELEASE;
        end else if (bus.arrive_req) begin
          op_d    = OP_ARRIVE;
          state_d = S_ALLOC;
        end
      end
      S_ALLOC: begin
        if (any_free) begin
          park_d = pick;
          cap_d  = cap_q ^ pick;
          cnt_d  = cnt_q - CNT_W'(1);
          full_d = 1'b0;
        end else begin
          park_d = '0;
          full_d = 1'b1;
        end
        state_d = S_RESP;
      end
      S_RELEASE: begin
        if (loc_legal) begin
          cap_d = cap_q ^ loc_q;
          cnt_d = cnt_q + CNT_W'(1);
          err_d = 1'b0;
        end else begin
          err_d = 1'b1;
        end
        state_d = S_RESP;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= OP_ARRIVE;
      loc_q   <= '0;
      cap_q   <= '0;
      cnt_q   <= CNT_W'(N_SPOTS);
      park_q  <= '0;
      full_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      loc_q   <= loc_d;
      cap_q   <= cap_d;
      cnt_q   <= cnt_d;
      park_q  <= park_d;
      full_q  <= full_d;
      err_q   <= err_d;
    end
  end

  // Status flags are masked by their ack so stale values never leak out.
  assign bus.arrive_ack       = (state_q == S_RESP) && (op_q == OP_ARRIVE);
  assign bus.depart_ack       = (state_q == S_RESP) && (op_q == OP_DEPART);
  assign bus.arrive_full      = bus.arrive_ack & full_q;
  assign bus.depart_err       = bus.depart_ack & err_q;
  assign bus.park_location    = park_q;
  assign bus.parking_capacity = cap_q;
  assign bus.free_count       = cnt_q;
  assign bus.busy             = (state_q != S_IDLE);
endmodule
`default_nettype wire

// File: doc/parking_spot_allocator.md
Name: parking_spot_allocator

Overview:
- Sequential front end of the parking-lot datapath. Owns the 8-spot occupancy bitmap.
- Arrival requests: picks the lowest-index free spot and returns it as a one-hot park_location.
- Departure requests: validates a one-hot exit location and frees that spot.
- Bitmap updates are a one-hot XOR toggle, so the same location vector is consumed downstream for capacity updates.

Parameters:
- N_SPOTS, 8, number of parking spots; bitmap width and one-hot location width.
- CNT_W, 4, width of free_count; must hold N_SPOTS (ceil(log2(N_SPOTS+1))).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- arrive_req  input  1  car at entry gate; sampled only in IDLE.
- arrive_ack  output  1  one-cycle pulse; arrival decision valid this cycle.
- arrive_full  output  1  qualifies arrive_ack; 1 = no free spot, request rejected.
- park_location  output  N_SPOTS  one-hot granted spot; valid with arrive_ack; 0 when full.
- depart_req  input  1  car at exit gate; sampled only in IDLE.
- depart_location  input  N_SPOTS  one-hot spot being vacated; sampled with depart_req.
- depart_ack  output  1  one-cycle pulse; departure processed.
- depart_err  output  1  qualifies depart_ack; 1 = illegal location, bitmap untouched.
- parking_capacity  output  N_SPOTS  occupancy bitmap; 1 = occupied; registered.
- free_count  output  CNT_W  number of zero bits in parking_capacity; registered.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset: state IDLE; parking_capacity 0; free_count N_SPOTS; all ack/err/full/busy 0; park_location 0. Reset mid-transaction aborts it silently, with no ack.
- FSM states: IDLE, ALLOC, RELEASE, RESP.
- IDLE:
  - depart_req=1 -> latch depart_location, go to RELEASE.
  - Else arrive_req=1 -> go to ALLOC.
  - Simultaneous requests: departure wins. Arrival stays pending as long as arrive_req is held.
- ALLOC (1 cycle):
  - Lowest-index zero bit of parking_capacity is encoded one-hot.
  - If one exists: register it to park_location, parking_capacity <= parking_capacity XOR pick, free_count - 1, full flag 0.
  - If none: park_location 0, bitmap unchanged, full flag 1.
  - Go to RESP.
- RELEASE (1 cycle):
  - Legal means latched location has exactly one bit set AND that bit is 1 in parking_capacity.
  - If legal: parking_capacity <= parking_capacity XOR location, free_count + 1, err flag 0.
  - Else (zero bits, multiple bits, or spot already free): err flag 1, bitmap and count unchanged.
  - Go to RESP.
- RESP (1 cycle):
  - Pulse arrive_ack (with arrive_full) or depart_ack (with depart_err) according to the originating op. Never both.
  - park_location holds its value until the next ALLOC.
  - Return to IDLE.
- Latency: request sampled in IDLE at cycle T; bitmap updated at edge T+2; ack high during cycle T+2; next request is accepted at earliest in cycle T+3.
- Handshake:
  - Requesters must drop req after seeing ack. A req still high in IDLE after RESP is treated as a new request.
  - depart_location must be stable only in the sampling cycle.
- Invariants: free_count always equals N_SPOTS minus popcount(parking_capacity). free_count never underflows or overflows.
- Requests arriving while busy=1 are ignored, not queued.

Decomposition:
- Shared package parking_pkg: N_SPOTS, CNT_W, FSM state encoding (IDLE=0, ALLOC=1, RELEASE=2, RESP=3), op-type constant (OP_ARRIVE, OP_DEPART).
- One combinational sub-module, lowest_free_picker: input occupancy bitmap; outputs one-hot pick of lowest zero bit and an any_free flag.
- Legality check (one-hot test via x & (x-1) == 0, x != 0) stays inline.

Test Plan:
- Reset, then 3 arrivals -> park_location 00000001, 00000010, 00000100; parking_capacity 00000111; free_count 5; each ack exactly 2 cycles after req sampled.
- Preload 8 arrivals, then a 9th -> arrive_ack=1, arrive_full=1, park_location 00000000, capacity 11111111, free_count 0.
- Capacity 00000111, depart 00000010 -> depart_ack=1, err=0, capacity 00000101. Next arrival -> park_location 00000010 (lowest hole reused).
- Illegal departures with capacity 00000101: 00000010 (free spot), 00000101 (two bits), 00000000 -> each depart_err=1, capacity unchanged, free_count 6.
- arrive_req and depart_req both high in IDLE, capacity 11111111, depart 10000000 -> depart processed first (capacity 01111111). Held arrive_req then granted 10000000, arrive_full=0.
- reset asserted during ALLOC after one prior grant -> no ack, capacity 0, free_count 8, busy 0 on the cycle after reset.
